// File: rtl/vend_dispense_sched.sv
// Purpose : shares one dispense motor and one change hopper among NREQ vending
//           front-ends; round-robin pick, dispense goods, then pay change coin by coin.
// Latency : grant (and motor_en when goods!=0) one cycle after req is seen in IDLE;
//           done/err pulse one cycle after the last mechanism handshake or timeout.
// Backpr. : requesters hold req until their done pulse; the mechanisms throttle the
//           sequence through motor_done / coin_ack, bounded by a TMO_CYC-cycle timeout.
//
// Ports
//   clk, rstn          clock (posedge) and synchronous active-low reset
//   i_req              per-requester pending flag, held until o_done[i]
//   i_goods_flat       2-bit goods id per requester (0 = refund only)
//   i_change_flat      3-bit coin count per requester
//   i_motor_done       dispense mechanism finished (level or pulse)
//   i_coin_ack         hopper confirms one coin ejected
//   o_grant            one-hot requester being served, 0 when idle
//   o_done / o_err     one-cycle completion pulse / fault flag with it
//   o_motor_en/_sel    dispense motor drive and goods id
//   o_coin_pulse       one-cycle eject-one-coin strobe
//   o_busy             high in every state except IDLE
module vend_dispense_sched #(
    parameter int NREQ    = 4,
    parameter int TMO_CYC = 60
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      i_req,
    input  logic [2*NREQ-1:0]    i_goods_flat,
    input  logic [3*NREQ-1:0]    i_change_flat,
    input  logic                 i_motor_done,
    input  logic                 i_coin_ack,
    output logic [NREQ-1:0]      o_grant,
    output logic [NREQ-1:0]      o_done,
    output logic                 o_err,
    output logic                 o_motor_en,
    output logic [1:0]           o_motor_sel,
    output logic                 o_coin_pulse,
    output logic                 o_busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TMO_CYC) + 1;

    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);
    localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DISP      = 3'd1,
        S_PAY_PULSE = 3'd2,
        S_PAY_WAIT  = 3'd3,
        S_FIN       = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [PW-1:0]      r_ptr;
    logic [TW-1:0]      r_tmo;
    logic [1:0]         r_goods;
    logic [2:0]         r_coins;
    logic [NREQ-1:0]    r_grant;
    logic [NREQ-1:0]    r_done;
    logic               r_err;
    logic               r_motor_en;
    logic [1:0]         r_motor_sel;
    logic               r_coin_pulse;
    logic               r_busy;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    state_t             w_state_nxt;
    logic               w_pick_vld;
    logic [PW-1:0]      w_pick_idx;
    logic [PW-1:0]      w_cand;
    logic [PW:0]        w_sum;
    logic [NREQ-1:0]    w_pick_oh;
    logic [1:0]         w_pick_goods;
    logic [2:0]         w_pick_coins;
    logic [PW-1:0]      w_ptr_nxt;
    logic [2:0]         w_coins_dec;
    logic               w_tmo_hit;
    logic               w_fault;

    // Round-robin search: candidates ptr, ptr+1, ... wrapped modulo NREQ
    // (NREQ need not be a power of two, so the wrap is an explicit subtract).
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_cand     = '0;
        w_sum      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= NREQ_W) begin
                w_sum = w_sum - NREQ_W;
            end
            w_cand = w_sum[PW-1:0];
            if (!w_pick_vld && i_req[w_cand]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_cand;
            end
        end
    end

    // Winner decode: one-hot grant plus its goods / change fields.
    always_comb begin
        w_pick_oh    = '0;
        w_pick_goods = 2'd0;
        w_pick_coins = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_pick_idx == PW'(k)) begin
                w_pick_oh[k] = w_pick_vld;
                w_pick_goods = i_goods_flat[2*k +: 2];
                w_pick_coins = i_change_flat[3*k +: 3];
            end
        end
    end

    assign w_ptr_nxt = (w_pick_idx == PTR_LAST) ? '0 : (w_pick_idx + PTR_ONE);

    // Next-state logic. A mechanism handshake arriving on the timeout cycle
    // is treated as success: the handshake is tested before the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_fault     = 1'b0;
        w_tmo_hit   = (r_tmo == TMO_LAST);
        w_coins_dec = r_coins - 3'd1;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    if (w_pick_goods != 2'd0) begin
                        w_state_nxt = S_DISP;
                    end else if (w_pick_coins != 3'd0) begin
                        w_state_nxt = S_PAY_PULSE;
                    end else begin
                        w_state_nxt = S_FIN;
                    end
                end
            end
            S_DISP: begin
                if (i_motor_done) begin
                    w_state_nxt = (r_coins != 3'd0) ? S_PAY_PULSE : S_FIN;
                end else if (w_tmo_hit) begin
                    // Dispense failed: change is deliberately not paid.
                    w_state_nxt = S_FIN;
                    w_fault     = 1'b1;
                end
            end
            S_PAY_PULSE: begin
                w_state_nxt = S_PAY_WAIT;
            end
            S_PAY_WAIT: begin
                if (i_coin_ack) begin
                    w_state_nxt = (w_coins_dec == 3'd0) ? S_FIN : S_PAY_PULSE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_FIN;
                    w_fault     = 1'b1;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs. Outputs are computed from the next
    // state so that they line up with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ptr        <= '0;
            r_tmo        <= '0;
            r_goods      <= 2'd0;
            r_coins      <= 3'd0;
            r_grant      <= '0;
            r_done       <= '0;
            r_err        <= 1'b0;
            r_motor_en   <= 1'b0;
            r_motor_sel  <= 2'd0;
            r_coin_pulse <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // Timeout counter restarts on every state entry and idles at 0.
            if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TMO_ONE;
            end

            // Transaction fields are latched once at arbitration, so later
            // changes on the request inputs cannot disturb the service.
            if ((r_state == S_IDLE) && w_pick_vld) begin
                r_goods <= w_pick_goods;
                r_coins <= w_pick_coins;
                r_ptr   <= w_ptr_nxt;
            end else if ((r_state == S_PAY_WAIT) && i_coin_ack) begin
                r_coins <= w_coins_dec;
            end

            // Grant stays up through FIN (overlapping done) and drops on
            // the return to IDLE; it doubles as the winner record.
            if (w_state_nxt == S_IDLE) begin
                r_grant <= '0;
            end else if (r_state == S_IDLE) begin
                r_grant <= w_pick_oh;
            end

            if (w_state_nxt == S_FIN) begin
                r_done <= (r_state == S_IDLE) ? w_pick_oh : r_grant;
            end else begin
                r_done <= '0;
            end
            r_err <= w_fault;

            r_motor_en <= (w_state_nxt == S_DISP);
            if (w_state_nxt == S_DISP) begin
                r_motor_sel <= (r_state == S_IDLE) ? w_pick_goods : r_goods;
            end else begin
                r_motor_sel <= 2'd0;
            end

            r_coin_pulse <= (w_state_nxt == S_PAY_PULSE);
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign o_grant      = r_grant;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_motor_en   = r_motor_en;
    assign o_motor_sel  = r_motor_sel;
    assign o_coin_pulse = r_coin_pulse;
    assign o_busy       = r_busy;

endmodule
